// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter and sequencer for the shared single-port 2048x32 main memory.
// Registered one-hot grant, bounded hold time, and a tagged read-return pipeline.
module mem_port_arbiter #(
   parameter int NREQ     = 3,
   parameter int AW       = 11,
   parameter int DW       = 32,
   parameter int RD_LAT   = 2,
   parameter int MAX_HOLD = 64
) (
   input  logic                 CLOCK_50,
   input  logic                 resetIn,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   addr_flat,
   input  logic [NREQ-1:0]      we_flat,
   input  logic [NREQ*DW-1:0]   wdata_flat,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [DW-1:0]        rdata,
   output logic                 busy,
   output logic [AW-1:0]        mem_addr,
   output logic                 mem_we,
   output logic [DW-1:0]        mem_wdata,
   input  logic [DW-1:0]        mem_rdata
);

   localparam int IW = $clog2(NREQ);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

   state_t            state;
   logic [IW-1:0]     owner;
   logic [IW-1:0]     rr_ptr;
   logic [HW-1:0]     hold_cnt;
   logic [IW-1:0]     pick;
   logic              pick_vld;
   logic [AW-1:0]     own_addr;
   logic [DW-1:0]     own_wdata;
   logic              own_req;
   logic              own_we;
   logic              in_own;
   logic              rd_push;
   logic              exit_own;
   logic [RD_LAT-1:0] tag_vld;
   logic [IW-1:0]     tag_id [RD_LAT];

   always_comb begin
      own_addr  = '0;
      own_wdata = '0;
      own_req   = 1'b0;
      own_we    = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         if (owner == IW'(k)) begin
            own_addr  = addr_flat[k*AW +: AW];
            own_wdata = wdata_flat[k*DW +: DW];
            own_req   = req[k];
            own_we    = we_flat[k];
         end
      end
   end

   // Scan from rr_ptr upward with wrap; the first set request wins.
   always_comb begin
      int unsigned idx;
      idx      = 0;
      pick     = rr_ptr;
      pick_vld = 1'b0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         idx = (int'(rr_ptr) + i) % NREQ;
         if (!pick_vld && req[idx]) begin
            pick     = IW'(idx);
            pick_vld = 1'b1;
         end
      end
   end

   assign in_own    = (state == OWN);
   assign mem_addr  = in_own ? own_addr  : '0;
   assign mem_wdata = in_own ? own_wdata : '0;
   assign mem_we    = in_own & own_req & own_we;
   assign rd_push   = in_own & own_req & ~own_we;
   assign exit_own  = ~own_req | ((hold_cnt == HOLD_LAST) && (|(req & ~gnt)));

   always_ff @(posedge CLOCK_50 or negedge resetIn) begin
      if (!resetIn) begin
         state    <= IDLE;
         gnt      <= '0;
         owner    <= '0;
         rr_ptr   <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  state    <= OWN;
                  owner    <= pick;
                  gnt      <= NREQ'(1) << pick;
                  hold_cnt <= '0;
               end
            end
            OWN: begin
               if (exit_own) begin
                  state    <= TURN;
                  gnt      <= '0;
                  rr_ptr   <= (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                  hold_cnt <= '0;
               end else if (hold_cnt != HOLD_LAST) begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            TURN:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Tags follow each read address through the memory latency so the
   // return reaches the issuer even after it has lost the grant.
   always_ff @(posedge CLOCK_50 or negedge resetIn) begin
      if (!resetIn) begin
         tag_vld <= '0;
         for (int unsigned i = 0; i < RD_LAT; i++) tag_id[i] <= '0;
      end else begin
         tag_vld[0] <= rd_push;
         tag_id[0]  <= owner;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            tag_vld[i] <= tag_vld[i-1];
            tag_id[i]  <= tag_id[i-1];
         end
      end
   end

   assign rvalid = tag_vld[RD_LAT-1] ? (NREQ'(1) << tag_id[RD_LAT-1]) : '0;
   assign rdata  = mem_rdata;
   assign busy   = (state != IDLE) | (|tag_vld);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed phases plus a read-return scoreboard
// against a 2-cycle-latency memory model and a shadow copy of its contents.
module tb_mem_port_arbiter;

   logic          CLOCK_50;
   logic          resetIn;
   logic [2:0]    req;
   logic [32:0]   addr_flat;
   logic [2:0]    we_flat;
   logic [95:0]   wdata_flat;
   logic [2:0]    gnt;
   logic [2:0]    rvalid;
   logic [31:0]   rdata;
   logic          busy;
   logic [10:0]   mem_addr;
   logic          mem_we;
   logic [31:0]   mem_wdata;
   logic [31:0]   mem_rdata;

   logic          pre_we;
   logic [10:0]   pre_addr;
   logic [31:0]   pre_data;
   logic [31:0]   mem_model [2048];
   logic [31:0]   shadow [2048];
   logic [31:0]   rd_q1;

   typedef struct {
      logic [1:0]  id;
      logic [31:0] data;
   } sb_t;
   sb_t sbq[$];

   int n_total = 0;
   int n_bad   = 0;
   int we_cnt  = 0;

   logic [10:0] pl_a [6] = '{11'd5, 11'd20, 11'd21, 11'd22, 11'd30, 11'd31};
   logic [31:0] pl_d [6] = '{32'hA5A5_0005, 32'h1111_0020, 32'h2222_0021,
                             32'h3333_0022, 32'h4444_0030, 32'h5555_0031};

   mem_port_arbiter #(.NREQ(3), .AW(11), .DW(32), .RD_LAT(2), .MAX_HOLD(4)) dut (
      .CLOCK_50   (CLOCK_50),
      .resetIn    (resetIn),
      .req        (req),
      .addr_flat  (addr_flat),
      .we_flat    (we_flat),
      .wdata_flat (wdata_flat),
      .gnt        (gnt),
      .rvalid     (rvalid),
      .rdata      (rdata),
      .busy       (busy),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else if (pre_we) mem_model[pre_addr] <= pre_data;
      rd_q1     <= mem_model[mem_addr];
      mem_rdata <= rd_q1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_port(input int k, input logic [10:0] a, input logic w, input logic [31:0] d);
      addr_flat[k*11 +: 11]  = a;
      we_flat[k]             = w;
      wdata_flat[k*32 +: 32] = d;
   endtask

   task automatic monitor();
      logic exp_we;
      logic [10:0] a;
      sb_t e;
      if (!resetIn) begin
         sbq.delete();
         return;
      end
      chk("onehot", 32'($onehot0(gnt)), 32'd1);
      exp_we = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (gnt[k] && req[k]) begin
            exp_we = we_flat[k];
            chk("mem_addr", 32'(mem_addr), 32'(addr_flat[k*11 +: 11]));
         end
      end
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      if (mem_we) we_cnt++;
      if (rvalid != 3'b000) begin
         if (sbq.size() == 0) begin
            chk("rv_unexp", 32'(rvalid), 32'd0);
         end else begin
            e = sbq.pop_front();
            chk("rv_id", 32'(rvalid), 32'(3'b001 << e.id));
            chk("rdata", rdata, e.data);
         end
      end
      for (int k = 0; k < 3; k++) begin
         if (gnt[k] && req[k]) begin
            a = addr_flat[k*11 +: 11];
            if (we_flat[k]) begin
               shadow[a] = wdata_flat[k*32 +: 32];
            end else begin
               e.id   = 2'(k);
               e.data = shadow[a];
               sbq.push_back(e);
            end
         end
      end
      if (pre_we) shadow[pre_addr] = pre_data;
   endtask

   task automatic cyc();
      @(negedge CLOCK_50);
      monitor();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic wait_own(input int k);
      for (int n = 0; n < 16 && !gnt[k]; n++) cyc();
      chk("own_wait", 32'(gnt[k]), 32'd1);
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40 && busy; n++) cyc();
      chk("idle_wait", 32'(busy), 32'd0);
   endtask

   task automatic access(input int k, input logic [10:0] a, input logic w, input logic [31:0] d);
      set_port(k, a, w, d);
      wait_own(k);
      cyc();
   endtask

   task automatic reset_pulse();
      resetIn = 1'b0;
      cyc();
      resetIn = 1'b1;
   endtask

   function automatic logic [2:0] rot_gnt(input int c);
      int p;
      if (c == 0) return 3'b000;
      p = (c - 1) % 6;
      if (p < 4) return 3'b001 << (((c - 1) / 6) % 3);
      return 3'b000;
   endfunction

   initial begin
      resetIn    = 1'b0;
      req        = '0;
      addr_flat  = '0;
      we_flat    = '0;
      wdata_flat = '0;
      pre_we     = 1'b0;
      pre_addr   = '0;
      pre_data   = '0;
      repeat (3) cyc();
      chk("rst_gnt", 32'(gnt), 32'd0);
      chk("rst_rvalid", 32'(rvalid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      resetIn = 1'b1;

      for (int i = 0; i < 6; i++) begin
         pre_we   = 1'b1;
         pre_addr = pl_a[i];
         pre_data = pl_d[i];
         cyc();
      end
      pre_we = 1'b0;

      // Single read from requester 1.
      set_port(1, 11'd5, 1'b0, 32'd0);
      req = 3'b010;
      chk("t1_lat0", 32'(gnt), 32'd0);
      cyc();
      chk("t1_gnt", 32'(gnt), 32'b010);
      cyc();
      chk("t1_rv_early", 32'(rvalid), 32'd0);
      cyc();
      chk("t1_rv", 32'(rvalid), 32'b010);
      chk("t1_rdata", rdata, 32'hA5A5_0005);
      req = 3'b000;
      wait_idle();

      // Write burst from requester 0, then read back through requester 1.
      we_cnt = 0;
      req = 3'b001;
      for (int i = 0; i < 4; i++) access(0, 11'(10 + i), 1'b1, 32'(i + 1));
      req     = 3'b000;
      we_flat = 3'b000;
      #1;
      chk("t2_drop_we", 32'(mem_we), 32'd0);
      cyc();
      chk("t2_turn_gnt", 32'(gnt), 32'd0);
      chk("t2_turn_we", 32'(mem_we), 32'd0);
      wait_idle();
      chk("t2_we_cnt", 32'(we_cnt), 32'd4);
      req = 3'b010;
      for (int i = 0; i < 4; i++) access(1, 11'(10 + i), 1'b0, 32'd0);
      req = 3'b000;
      wait_idle();

      // Rotation under continuous contention.
      reset_pulse();
      set_port(0, 11'd20, 1'b0, 32'd0);
      set_port(1, 11'd21, 1'b0, 32'd0);
      set_port(2, 11'd22, 1'b0, 32'd0);
      req = 3'b111;
      for (int c = 0; c < 23; c++) begin
         chk($sformatf("t3_gnt_c%0d", c), 32'(gnt), 32'(rot_gnt(c)));
         cyc();
      end
      req = 3'b000;
      wait_idle();

      // Lone requester is never revoked.
      req = 3'b100;
      wait_own(2);
      for (int c = 0; c < 200; c++) begin
         chk("t4_gnt", 32'(gnt), 32'b100);
         cyc();
      end
      req = 3'b000;
      wait_idle();

      // Reset mid-burst with reads in flight.
      set_port(1, 11'd5, 1'b0, 32'd0);
      req = 3'b010;
      wait_own(1);
      cyc();
      cyc();
      #1 resetIn = 1'b0;
      #1;
      chk("t5_gnt", 32'(gnt), 32'd0);
      chk("t5_we", 32'(mem_we), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_rvalid", 32'(rvalid), 32'd0);
      set_port(0, 11'd5, 1'b0, 32'd0);
      set_port(2, 11'd22, 1'b0, 32'd0);
      req = 3'b101;
      cyc();
      resetIn = 1'b1;
      chk("t5_idle_gnt", 32'(gnt), 32'd0);
      chk("t5_idle_rv", 32'(rvalid), 32'd0);
      cyc();
      chk("t5_next_gnt", 32'(gnt), 32'b001);
      chk("t5_rv_a", 32'(rvalid), 32'd0);
      cyc();
      chk("t5_rv_b", 32'(rvalid), 32'd0);
      req = 3'b000;
      wait_idle();

      // Read in the last owned cycle before a forced rotation still returns.
      reset_pulse();
      set_port(0, 11'd30, 1'b0, 32'd0);
      set_port(1, 11'd31, 1'b0, 32'd0);
      req = 3'b011;
      for (int c = 0; c < 11; c++) begin
         if (c == 6) begin
            chk("t6_rv_late", 32'(rvalid), 32'b001);
            chk("t6_gnt_gap", 32'(gnt), 32'd0);
            chk("t6_rdata", rdata, 32'h4444_0030);
         end
         if (c == 7) begin
            chk("t6_gnt1", 32'(gnt), 32'b010);
            chk("t6_rv_none", 32'(rvalid), 32'd0);
         end
         if (c == 9) chk("t6_rv1", 32'(rvalid), 32'b010);
         cyc();
      end
      req = 3'b000;
      wait_idle();

      chk("sb_left", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Arbiter and sequencer for the single-port 2048x32 main memory shared by the write-to-RAM engine, the VGA draw engine and the keyboard modify path. It replaces ad-hoc state-based address muxing with a registered round-robin grant, a per-requester read-valid pipeline and a bounded hold time. It sits directly between the requesters and the mainMemory instance.

Parameters:
NREQ, 3, number of requesters (0=write engine, 1=draw engine, 2=modify path); the design is fixed at 3
AW, 11, memory address width
DW, 32, memory data width
RD_LAT, 2, memory read latency in cycles, from address presented to mem_rdata valid
MAX_HOLD, 64, maximum consecutive owned cycles before a forced rotation while others are waiting

Ports:
CLOCK_50  in  1  system clock; all state on rising edge
resetIn  in  1  asynchronous active-low reset
req  in  3  per-requester access request; level, held for the whole burst
addr_flat  in  33  requester k address at [11k+10:11k]
we_flat  in  3  per-requester write enable
wdata_flat  in  96  requester k write data at [32k+31:32k]
gnt  out  3  registered one-hot grant
rvalid  out  3  one-cycle pulse per completed read, routed to the issuing requester
rdata  out  32  mem_rdata forwarded; meaningful only when some rvalid bit is set
busy  out  1  high while any grant is held or any read is in flight
mem_addr  out  11  to memory address
mem_we  out  1  to memory write enable
mem_wdata  out  32  to memory data
mem_rdata  in  32  from memory q

Behaviour:
- Reset, asynchronous on resetIn=0: gnt=0, rvalid=0, busy=0, state=IDLE, rr pointer=0, hold_cnt=0, read pipeline cleared. While idle: mem_addr=0, mem_we=0, mem_wdata=0. Reset mid-burst drops the grant at once and discards in-flight reads, with no rvalid for them.
- States: IDLE, OWN, TURN.
- IDLE: if req!=0, choose the first set bit scanning from rr pointer upward with wrap (2 then 0). Set gnt to that one-hot on the next edge and enter OWN. Grant latency is 1 cycle from req sampled high.
- OWN with owner k: mem_addr=addr[k], mem_wdata=wdata[k], mem_we=we[k]&req[k]. These are combinational from the requester inputs, so the access occurs in every cycle that gnt[k]&req[k] is high. hold_cnt increments each OWN cycle.
- OWN exits to TURN, clearing gnt on the edge, when req[k]=0 or when hold_cnt==MAX_HOLD-1 and (req & ~gnt)!=0. On entering TURN, rr pointer becomes (k+1) mod 3 and hold_cnt becomes 0.
- A lone requester is never revoked. hold_cnt saturates and the grant is kept.
- TURN: exactly one dead cycle with gnt=0 and mem_we=0, then return to IDLE. Back-to-back owners are therefore separated by 2 cycles (TURN plus IDLE arbitration).
- Requesters must treat a gnt fall as preemption. A write is committed only on a cycle where gnt was high at the edge.
- Read tracking: each OWN cycle with req[k]&~we[k] pushes tag {valid=1, id=k} into an RD_LAT-deep shift register. When the tag exits, rvalid[id] pulses for 1 cycle and rdata=mem_rdata. Reads issued before preemption or a req drop still return. Write cycles push valid=0.
- busy = (state!=IDLE) | any valid tag in the pipeline.
- Simultaneous requests from IDLE: the round-robin order decides. After reset with req=3'b111, owner order is 0,1,2,0...
- req falling and a hold expiry in the same cycle: treated as a single exit to TURN.
- Unknown owner index cannot occur. gnt is always one-hot or zero.

Test Plan:
1. Reset, then req=3'b010, we=0, addr1=5, memory preloaded with word5=32'hA5A5_0005 -> gnt=3'b010 one cycle later; rvalid[1] pulses RD_LAT cycles after the first owned read cycle with rdata=32'hA5A5_0005; rvalid[0] and rvalid[2] stay 0.
2. req0 holds a write burst to addr 10..13 with data 1..4, then drops -> mem_we high for exactly 4 cycles; TURN has mem_we=0; read-back through req1 returns 1,2,3,4.
3. req=3'b111 held continuously, MAX_HOLD=4 -> grants rotate 0,1,2,0; each grant lasts 4 cycles with a 2-cycle gap; no cycle shows more than one gnt bit.
4. Only req2 held for 200 cycles -> gnt[2] stays high throughout and is never revoked.
5. resetIn pulsed low during an owned read with 2 reads in flight -> gnt=0 and mem_we=0 immediately; no rvalid follows; busy=0; the next grant goes to requester 0 when req=3'b101.
6. Owner preempted via MAX_HOLD with a read issued in its final owned cycle -> rvalid for that read still arrives to the original requester, even though another requester now holds gnt.
